// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: branch/jump resolution sequencer for the Otter EX stage.
// It accepts one control-transfer op at a time, compares the operands, decides
// the direction, computes the next PC, flags mispredicts (redirect + a single
// flush pulse) and trains a 2-bit saturating branch history table read by IF.
//
// Handshakes: an op transfers on ex_valid & ex_ready, and a result transfers on
// res_valid & res_ready. Once res_valid rises, every res_* output, redirect and
// illegal_br stay stable until that transfer. Only the FSM's own state decides
// ex_ready and res_valid; neither depends on ex_valid or res_ready.
//
// Optional build macro: BRANCH_STATS_EN adds branch and mispredict counters
// (stat_branches, stat_mispredicts, stat_clr).
module branch_resolve_ctrl #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_func3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [XLEN-1:0] res_target,
    output logic            redirect,
    output logic            flush,
    output logic            illegal_br,
`ifdef BRANCH_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts,
    input  logic            stat_clr,
`endif
    output logic [1:0]      dbg_state_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Latched op (type already reduced to one-hot by priority jal > jalr > branch)
    logic            op_br_q, op_jal_q, op_jalr_q, pred_q;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;

    // Resolution results
    logic            taken_q, mispred_q, illegal_q, upd_q, flush_q;
    logic [XLEN-1:0] target_q;

    // Branch history table
    logic [1:0]      bht_q [BHT_ENTRIES];

    logic            any_type;
    logic            accept;
    logic            res_hs;
    logic            bht_we;
    logic [IDX_W-1:0] upd_idx;

    // Evaluation results, combinational from the latched op
    logic            eq, lt, ltu;
    logic            br_cond, br_legal;
    logic            eval_taken, eval_illegal, eval_upd, eval_mispred;
    logic [XLEN-1:0] eval_target;

    assign any_type = ex_is_branch | ex_is_jal | ex_is_jalr;
    assign accept   = (state_q == S_IDLE) && ex_valid && any_type;
    assign res_hs   = (state_q == S_RESP) && res_ready;
    assign upd_idx  = pc_q[IDX_W+1:2];
    assign bht_we   = res_hs && upd_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; ops with no type bit set are dropped while staying IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ex_valid && any_type) state_d = S_EVAL;
            S_EVAL:  state_d = S_RESP;
            S_RESP:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the op on acceptance; ex_* is ignored in every other state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_br_q   <= 1'b0;
            op_jal_q  <= 1'b0;
            op_jalr_q <= 1'b0;
            pred_q    <= 1'b0;
            func3_q   <= 3'd0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
        end else if (accept) begin
            op_jal_q  <= ex_is_jal;
            op_jalr_q <= !ex_is_jal && ex_is_jalr;
            op_br_q   <= !ex_is_jal && !ex_is_jalr && ex_is_branch;
            pred_q    <= ex_pred_taken;
            func3_q   <= ex_func3;
            pc_q      <= ex_pc;
            rs1_q     <= ex_rs1;
            rs2_q     <= ex_rs2;
            imm_q     <= ex_imm;
        end
    end

    // Compare, direction decode, target and mispredict for the latched op
    always_comb begin
        eq  = (rs1_q == rs2_q);
        lt  = ($signed(rs1_q) < $signed(rs2_q));
        ltu = (rs1_q < rs2_q);

        br_cond  = 1'b0;
        br_legal = 1'b1;
        case (func3_q)
            3'b000:  br_cond = eq;
            3'b001:  br_cond = !eq;
            3'b100:  br_cond = lt;
            3'b101:  br_cond = !lt;
            3'b110:  br_cond = ltu;
            3'b111:  br_cond = !ltu;
            default: br_legal = 1'b0;
        endcase

        eval_taken   = op_jal_q || op_jalr_q || (op_br_q && br_legal && br_cond);
        eval_illegal = op_br_q && !br_legal;
        eval_upd     = op_br_q && br_legal;

        if (op_jalr_q)       eval_target = (rs1_q + imm_q) & ~XLEN'(1);
        else if (eval_taken) eval_target = pc_q + imm_q;
        else                 eval_target = pc_q + XLEN'(4);

        eval_mispred = (eval_taken != pred_q);
    end

    // Result registers load in EVAL; flush is armed only for the first RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q   <= 1'b0;
            target_q  <= '0;
            mispred_q <= 1'b0;
            illegal_q <= 1'b0;
            upd_q     <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            flush_q <= (state_q == S_EVAL) && eval_mispred;
            if (state_q == S_EVAL) begin
                taken_q   <= eval_taken;
                target_q  <= eval_target;
                mispred_q <= eval_mispred;
                illegal_q <= eval_illegal;
                upd_q     <= eval_upd;
            end
        end
    end

    // BHT training on the result handshake of a legal conditional branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (bht_we) begin
            if (taken_q) begin
                if (bht_q[upd_idx] != 2'b11) bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            end else begin
                if (bht_q[upd_idx] != 2'b00) bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    // Saturating counters; clear wins over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (stat_clr) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (res_hs) begin
            if (upd_q && stat_br_q != 32'hFFFF_FFFF)     stat_br_q <= stat_br_q + 32'd1;
            if (mispred_q && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

    // Output decode; ex_ready is held low while reset is asserted
    assign ex_ready      = rst_n && (state_q == S_IDLE);
    assign res_valid     = (state_q == S_RESP);
    assign res_taken     = taken_q;
    assign res_target    = target_q;
    assign redirect      = res_valid && mispred_q;
    assign illegal_br    = res_valid && illegal_q;
    assign flush         = flush_q;
    assign if_pred_taken = bht_q[if_pc[IDX_W+1:2]][1];
    assign dbg_state_o   = state_q;

    // PC bits outside the BHT index do not take part in the lookup
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

endmodule
